// File: rtl/sdram_arb.sv
// ---------------------------------------------------------------------------
// sdram_arb
//
// Shares the single SDRAM controller command port between the VGA line-fetch
// engine (reads) and CPU pixel writes arriving over the td4 I/O bus. CPU
// writes land in a small FIFO so one-cycle iow strobes are never lost while
// video owns the memory. Video has priority. A starvation counter forces one
// CPU grant after STARVE_MAX consecutive video grants taken while CPU data
// was waiting.
//
// Register block (relative to IO_BASE, decoded on iow):
//   +0  ADDR[15:0]    <= iowdt
//   +1  ADDR[AW-1:16] <= iowdt[AW-17:0]
//   +2  push {ADDR, iowdt} into the FIFO, then ADDR <= ADDR + 1
//   +3  clear the sticky overflow flag
//
// Ports:
//   clk150     in   1   sole clock
//   reset      in   1   asynchronous, active-high
//   ioad       in   8   td4 I/O address
//   iowdt      in   16  td4 I/O write data
//   iow        in   1   one-cycle write strobe
//   wbusy      out  1   CPU write FIFO is full
//   ovf        out  1   sticky: a CPU data write was dropped
//   vreq       in   1   video read request (level, held until vack)
//   vaddr      in   AW  video read address (stable while vreq is high)
//   vack       out  1   pulse: video command accepted by the controller
//   vdone      out  1   pulse: video read complete
//   mem_req    out  1   command valid
//   mem_we     out  1   1 = write, 0 = read
//   mem_addr   out  AW  command address
//   mem_wdata  out  16  write data
//   mem_ack    in   1   controller accepted the command
//   mem_done   in   1   controller finished the command
// ---------------------------------------------------------------------------
module sdram_arb #(
  parameter int         AW         = 24,
  parameter int         FIFO_DEPTH = 4,
  parameter int         STARVE_MAX = 4,
  parameter logic [7:0] IO_BASE    = 8'h80
) (
  input  logic          clk150,
  input  logic          reset,
  input  logic [7:0]    ioad,
  input  logic [15:0]   iowdt,
  input  logic          iow,
  output logic          wbusy,
  output logic          ovf,
  input  logic          vreq,
  input  logic [AW-1:0] vaddr,
  output logic          vack,
  output logic          vdone,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic          mem_done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [7:0] A_ADDR_LO = IO_BASE;
  localparam logic [7:0] A_ADDR_HI = IO_BASE + 8'd1;
  localparam logic [7:0] A_PUSH    = IO_BASE + 8'd2;
  localparam logic [7:0] A_CLR_OVF = IO_BASE + 8'd3;

  localparam logic [CW-1:0] C_FULL       = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VID  = 2'd1,
    S_CPU  = 2'd2,
    S_WAIT = 2'd3
  } arbState_t;

  // Address register and FIFO state
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_fifoAddr [FIFO_DEPTH];
  logic [15:0]   r_fifoData [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_wbusy;
  logic          r_ovf;

  // Arbiter state and registered command outputs
  arbState_t     r_state;
  logic [SW-1:0] r_starve;
  logic          r_ownerVid;
  logic          r_memReq;
  logic          r_memWe;
  logic [AW-1:0] r_memAddr;
  logic [15:0]   r_memWdata;
  logic          r_vack;
  logic          r_vdone;

  // Decode and FIFO control
  logic          w_selAddrLo;
  logic          w_selAddrHi;
  logic          w_push;
  logic          w_clrOvf;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_drop;
  logic [CW-1:0] w_countNext;
  logic          w_starveFull;
  logic          w_vidWins;

  // I/O register decode. Only the strobe cycle matters; ioad/iowdt are
  // don't-care whenever iow is low.
  assign w_selAddrLo = iow && (ioad == A_ADDR_LO);
  assign w_selAddrHi = iow && (ioad == A_ADDR_HI);
  assign w_push      = iow && (ioad == A_PUSH);
  assign w_clrOvf    = iow && (ioad == A_CLR_OVF);

  // A pop happens exactly when the controller accepts a CPU command. The FSM
  // only enters CPU with a non-empty FIFO, so a pop never underflows.
  assign w_pop   = (r_state == S_CPU) && mem_ack;
  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // A push into a full FIFO still succeeds if a slot frees up in the same
  // cycle; otherwise the data is lost and the overflow flag records it.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  // Video wins arbitration unless it has already starved waiting CPU data
  // for STARVE_MAX grants in a row.
  assign w_starveFull = (r_starve == C_STARVE_MAX);
  assign w_vidWins    = vreq && !(w_starveFull && !w_empty);

  // Occupancy after this cycle's push/pop. wbusy is registered from this
  // value so it already reflects the current cycle's traffic.
  always_comb begin
    w_countNext = r_count;
    if (w_accept && !w_pop) begin
      w_countNext = r_count + CW'(1);
    end else if (!w_accept && w_pop) begin
      w_countNext = r_count - CW'(1);
    end
  end

  // ADDR register. Data pushes post-increment it, wrapping modulo 2^AW, and
  // do so even when the data itself is dropped so software can keep a
  // running pointer without reading anything back.
  always_ff @(posedge clk150 or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_selAddrLo) begin
      r_addr[15:0] <= iowdt;
    end else if (w_selAddrHi) begin
      r_addr[AW-1:16] <= iowdt[AW-17:0];
    end else if (w_push) begin
      r_addr <= r_addr + AW'(1);
    end
  end

  // Sticky overflow flag: set by a dropped push, cleared only by software.
  always_ff @(posedge clk150 or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_clrOvf) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  // FIFO storage. Each entry captures the address current at push time, so
  // later ADDR writes never disturb queued entries. When full with a
  // simultaneous push and pop, the write slot equals the head slot; that is
  // safe because the head was copied into the command registers when the
  // FSM entered CPU, long before this edge.
  always_ff @(posedge clk150) begin
    if (w_accept) begin
      r_fifoAddr[r_wrPtr] <= r_addr;
      r_fifoData[r_wrPtr] <= iowdt;
    end
  end

  // FIFO pointers, occupancy and the registered full flag. Depth is a power
  // of two, so the pointers wrap naturally.
  always_ff @(posedge clk150 or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_wbusy <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_count <= w_countNext;
      r_wbusy <= (w_countNext == C_FULL);
    end
  end

  // Arbiter FSM with registered command outputs and the starvation counter.
  // IDLE picks a requester and loads the command registers, so mem_req rises
  // the cycle after the request is seen. VID/CPU hold the command until
  // mem_ack; WAIT holds off new commands until mem_done. Command fields keep
  // their last value after mem_req drops. vack/vdone are single-cycle pulses
  // defaulted low every cycle.
  always_ff @(posedge clk150 or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_starve   <= '0;
      r_ownerVid <= 1'b0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_vack     <= 1'b0;
      r_vdone    <= 1'b0;
    end else begin
      r_vack  <= 1'b0;
      r_vdone <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_vidWins) begin
            r_state   <= S_VID;
            r_memReq  <= 1'b1;
            r_memWe   <= 1'b0;
            r_memAddr <= vaddr;
          end else if (!w_empty) begin
            r_state    <= S_CPU;
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b1;
            r_memAddr  <= r_fifoAddr[r_rdPtr];
            r_memWdata <= r_fifoData[r_rdPtr];
          end
        end
        S_VID: begin
          if (mem_ack) begin
            r_state    <= S_WAIT;
            r_memReq   <= 1'b0;
            r_ownerVid <= 1'b1;
            r_vack     <= 1'b1;
          end
        end
        S_CPU: begin
          if (mem_ack) begin
            r_state    <= S_WAIT;
            r_memReq   <= 1'b0;
            r_ownerVid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            r_state <= S_IDLE;
            r_vdone <= r_ownerVid;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_memReq <= 1'b0;
        end
      endcase

      // Starvation count: a served CPU write or an empty FIFO resets it;
      // otherwise every video grant taken while CPU data waits bumps it,
      // saturating at STARVE_MAX.
      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if ((r_state == S_VID) && mem_ack && !w_starveFull) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  assign wbusy     = r_wbusy;
  assign ovf       = r_ovf;
  assign vack      = r_vack;
  assign vdone     = r_vdone;
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_sdram_arb.sv
// ---------------------------------------------------------------------------
// tb_sdram_arb
//
// Directed bench for sdram_arb. Stimulus pushes the commands it expects the
// arbiter to issue into a queue; a monitor pops one entry each time the
// controller accepts a command and compares it. A small controller model
// answers commands with mem_ack 2 cycles and mem_done 5 cycles after
// mem_req, and can be switched off so the bench drives mem_ack by hand.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
// ---------------------------------------------------------------------------
module tb_sdram_arb;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
    logic        chk;
  } cmd_t;

  logic        clk150 = 1'b0;
  logic        reset;
  logic [7:0]  ioad;
  logic [15:0] iowdt;
  logic        iow;
  logic        wbusy;
  logic        ovf;
  logic        vreq;
  logic [23:0] vaddr;
  logic        vack;
  logic        vdone;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        mem_done;

  int   passCount  = 0;
  int   checkCount = 0;
  int   grantCount = 0;
  bit   autoCtrl   = 1'b1;
  cmd_t expQ[$];

  sdram_arb #(
    .AW(24),
    .FIFO_DEPTH(4),
    .STARVE_MAX(4),
    .IO_BASE(8'h80)
  ) dut (
    .clk150(clk150),
    .reset(reset),
    .ioad(ioad),
    .iowdt(iowdt),
    .iow(iow),
    .wbusy(wbusy),
    .ovf(ovf),
    .vreq(vreq),
    .vaddr(vaddr),
    .vack(vack),
    .vdone(vdone),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_done(mem_done)
  );

  // 10-unit clock period
  always #5 clk150 = ~clk150;

  // Generic scalar comparison used by the stimulus and the monitor
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // One td4 I/O write cycle
  task automatic applyStimulus(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk150);
    ioad  = a;
    iowdt = d;
    iow   = 1'b1;
    @(negedge clk150);
    iow   = 1'b0;
  endtask

  task automatic expectCmd(input logic we, input logic [23:0] a,
                           input logic [15:0] d, input logic chk);
    cmd_t e;
    e.we   = we;
    e.addr = a;
    e.data = d;
    e.chk  = chk;
    expQ.push_back(e);
  endtask

  // Wait until every expected command has been seen, then let the last
  // command finish its WAIT phase
  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(negedge clk150);
      n++;
    end
    if (expQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drainTimeout: %0d commands pending, want 0", expQ.size());
      expQ.delete();
    end
    repeat (10) @(negedge clk150);
  endtask

  task automatic waitGrants(input int target);
    int n = 0;
    while (grantCount < target && n < 600) begin
      @(negedge clk150);
      #3;
      n++;
    end
    if (grantCount < target) begin
      checkCount++;
      $display("[TB] FAIL grantTimeout: got %0d grants, want %0d", grantCount, target);
    end
  endtask

  // Controller model: ack 2 cycles and done 5 cycles after mem_req is seen
  initial begin : controller
    int cnt;
    bit busy;
    cnt  = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk150);
      if (autoCtrl) begin
        mem_ack  = 1'b0;
        mem_done = 1'b0;
        if (reset) begin
          busy = 1'b0;
        end else if (busy) begin
          cnt++;
          if (cnt == 2) mem_ack = 1'b1;
          if (cnt == 5) begin
            mem_done = 1'b1;
            busy     = 1'b0;
          end
        end else if (mem_req) begin
          busy = 1'b1;
          cnt  = 0;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // Monitor: compares every accepted command against the scoreboard and
  // checks the vack/vdone pulses that should follow video commands
  initial begin : monitor
    cmd_t e;
    bit   expVack;
    bit   expVdone;
    bit   waitVid;
    expVack  = 1'b0;
    expVdone = 1'b0;
    waitVid  = 1'b0;
    forever begin
      @(negedge clk150);
      #2;
      if (reset) begin
        expVack  = 1'b0;
        expVdone = 1'b0;
        waitVid  = 1'b0;
      end else begin
        if (expVack || vack) checkOutput("vack", 32'(vack), 32'(expVack));
        if (expVdone || vdone) checkOutput("vdone", 32'(vdone), 32'(expVdone));
        expVack  = 1'b0;
        expVdone = 1'b0;
        if (mem_req && mem_ack) begin
          grantCount++;
          checkCount++;
          if (expQ.size() == 0) begin
            $display("[TB] FAIL cmd%0d: got unexpected we=%0b addr=%h, want none",
                     grantCount, mem_we, mem_addr);
          end else begin
            e = expQ.pop_front();
            if (mem_we === e.we && mem_addr === e.addr &&
                (!e.chk || mem_wdata === e.data)) begin
              passCount++;
            end else begin
              $display("[TB] FAIL cmd%0d: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                       grantCount, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
            end
          end
          expVack = !mem_we;
          waitVid = !mem_we;
        end
        if (mem_done && waitVid) begin
          expVdone = 1'b1;
          waitVid  = 1'b0;
        end
      end
    end
  end

  // Safety net against a hung run
  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin : stimulus
    int base;
    reset    = 1'b1;
    ioad     = 8'h00;
    iowdt    = 16'h0000;
    iow      = 1'b0;
    vreq     = 1'b0;
    vaddr    = 24'h000000;
    mem_ack  = 1'b0;
    mem_done = 1'b0;

    // Reset values
    repeat (2) @(negedge clk150);
    #2;
    checkOutput("rstMemReq", 32'(mem_req), 32'h0);
    checkOutput("rstMemWe", 32'(mem_we), 32'h0);
    checkOutput("rstMemAddr", 32'(mem_addr), 32'h0);
    checkOutput("rstMemWdata", 32'(mem_wdata), 32'h0);
    checkOutput("rstVack", 32'(vack), 32'h0);
    checkOutput("rstVdone", 32'(vdone), 32'h0);
    checkOutput("rstWbusy", 32'(wbusy), 32'h0);
    checkOutput("rstOvf", 32'(ovf), 32'h0);
    @(negedge clk150);
    reset = 1'b0;

    // Single CPU write, then a second one proving ADDR advanced to 0x13
    $display("[TB] single CPU write");
    expectCmd(1'b1, 24'h000012, 16'hBEEF, 1'b1);
    expectCmd(1'b1, 24'h000013, 16'h1234, 1'b1);
    applyStimulus(8'h80, 16'h0012);
    applyStimulus(8'h81, 16'h0000);
    applyStimulus(8'h82, 16'hBEEF);
    applyStimulus(8'h82, 16'h1234);
    waitDrain();
    #2;
    checkOutput("fifoEmptyReq", 32'(mem_req), 32'h0);
    checkOutput("fifoEmptyWbusy", 32'(wbusy), 32'h0);

    // Starvation guard: vreq held, 3 CPU writes queued
    $display("[TB] starvation guard");
    applyStimulus(8'h80, 16'h0100);
    applyStimulus(8'h81, 16'h0000);
    vaddr = 24'h00ABCD;
    for (int g = 0; g < 15; g++) begin
      if (g % 5 == 4) expectCmd(1'b1, 24'h000100 + 24'(g / 5), 16'hA000 + 16'(g / 5), 1'b1);
      else            expectCmd(1'b0, 24'h00ABCD, 16'h0000, 1'b0);
    end
    base = grantCount;
    @(negedge clk150);
    vreq  = 1'b1;
    ioad  = 8'h82;
    iowdt = 16'hA000;
    iow   = 1'b1;
    @(negedge clk150);
    iow = 1'b0;
    applyStimulus(8'h82, 16'hA001);
    applyStimulus(8'h82, 16'hA002);
    waitGrants(base + 15);
    @(negedge clk150);
    vreq = 1'b0;
    waitDrain();

    // Starve counter back at 0: a fresh write again waits four video grants
    for (int g = 0; g < 4; g++) expectCmd(1'b0, 24'h00ABCD, 16'h0000, 1'b0);
    expectCmd(1'b1, 24'h000103, 16'hA003, 1'b1);
    base = grantCount;
    @(negedge clk150);
    vreq  = 1'b1;
    ioad  = 8'h82;
    iowdt = 16'hA003;
    iow   = 1'b1;
    @(negedge clk150);
    iow = 1'b0;
    waitGrants(base + 5);
    @(negedge clk150);
    vreq = 1'b0;
    waitDrain();

    // Overflow with the controller stalled
    $display("[TB] overflow");
    autoCtrl = 1'b0;
    mem_ack  = 1'b0;
    mem_done = 1'b0;
    applyStimulus(8'h80, 16'h0200);
    applyStimulus(8'h81, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h82, 16'hC000 + 16'(i));
      #2;
      if (i == 2) checkOutput("wbusyThree", 32'(wbusy), 32'h0);
      if (i == 3) begin
        checkOutput("wbusyFour", 32'(wbusy), 32'h1);
        checkOutput("ovfFour", 32'(ovf), 32'h0);
      end
      if (i == 4) begin
        checkOutput("ovfFive", 32'(ovf), 32'h1);
        checkOutput("wbusyFive", 32'(wbusy), 32'h1);
      end
    end
    for (int i = 0; i < 4; i++) expectCmd(1'b1, 24'h000200 + 24'(i), 16'hC000 + 16'(i), 1'b1);
    autoCtrl = 1'b1;
    waitDrain();
    #2;
    checkOutput("wbusyDrained", 32'(wbusy), 32'h0);
    checkOutput("ovfSticky", 32'(ovf), 32'h1);
    expectCmd(1'b1, 24'h000205, 16'hC005, 1'b1);
    applyStimulus(8'h82, 16'hC005);
    waitDrain();
    applyStimulus(8'h83, 16'h0000);
    #2;
    checkOutput("ovfCleared", 32'(ovf), 32'h0);

    // Push and pop in the same cycle while full
    $display("[TB] push/pop while full");
    autoCtrl = 1'b0;
    mem_ack  = 1'b0;
    mem_done = 1'b0;
    applyStimulus(8'h80, 16'h0300);
    applyStimulus(8'h81, 16'h0000);
    for (int i = 0; i < 5; i++) expectCmd(1'b1, 24'h000300 + 24'(i), 16'hD000 + 16'(i), 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(8'h82, 16'hD000 + 16'(i));
    @(negedge clk150);
    ioad    = 8'h82;
    iowdt   = 16'hD004;
    iow     = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk150);
    iow      = 1'b0;
    mem_ack  = 1'b0;
    mem_done = 1'b1;
    #2;
    checkOutput("wbusyPushPop", 32'(wbusy), 32'h1);
    checkOutput("ovfPushPop", 32'(ovf), 32'h0);
    @(negedge clk150);
    mem_done = 1'b0;
    autoCtrl = 1'b1;
    waitDrain();

    // Address wrap
    $display("[TB] address wrap");
    expectCmd(1'b1, 24'hFFFFFF, 16'h1111, 1'b1);
    expectCmd(1'b1, 24'h000000, 16'h2222, 1'b1);
    applyStimulus(8'h80, 16'hFFFF);
    applyStimulus(8'h81, 16'h00FF);
    applyStimulus(8'h82, 16'h1111);
    applyStimulus(8'h82, 16'h2222);
    waitDrain();

    // Reset while a video command is pending
    $display("[TB] reset mid-operation");
    vaddr = 24'h123456;
    @(negedge clk150);
    vreq = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk150);
      #2;
      if (mem_req) break;
    end
    checkOutput("vidReqSeen", 32'(mem_req), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midRstMemReq", 32'(mem_req), 32'h0);
    checkOutput("midRstMemWe", 32'(mem_we), 32'h0);
    checkOutput("midRstMemAddr", 32'(mem_addr), 32'h0);
    checkOutput("midRstMemWdata", 32'(mem_wdata), 32'h0);
    checkOutput("midRstVack", 32'(vack), 32'h0);
    checkOutput("midRstVdone", 32'(vdone), 32'h0);
    checkOutput("midRstWbusy", 32'(wbusy), 32'h0);
    checkOutput("midRstOvf", 32'(ovf), 32'h0);
    repeat (2) @(negedge clk150);
    expectCmd(1'b0, 24'h123456, 16'h0000, 1'b0);
    base  = grantCount;
    reset = 1'b0;
    @(negedge clk150);
    #2;
    checkOutput("reqAfterReset", 32'(mem_req), 32'h1);
    waitGrants(base + 1);
    @(negedge clk150);
    vreq = 1'b0;
    waitDrain();

    checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
